// File: rtl/capture_sink.sv
// capture_sink: stream sink that fills a circular sample buffer
// and drains it oldest-first through a valid/ready read port.
module capture_sink #(
  parameter int size   = 32,
  parameter int addr_w = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [size-1:0]   s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              start,
  input  logic              capture_done,
  input  logic              rd_start,
  output logic [size-1:0]   rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [addr_w:0]   sample_count,
  output logic              wrapped,
  output logic [1:0]        state
);

  localparam int depth = 1 << addr_w;
  localparam logic [addr_w:0] full = (addr_w+1)'(depth);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    FROZEN  = 2'd2,
    READOUT = 2'd3
  } st_t;

  st_t st;

  logic [addr_w-1:0] wp;
  logic [addr_w-1:0] rp;
  logic [addr_w-1:0] raddr;
  logic [addr_w:0]   remaining;
  logic [addr_w:0]   to_issue;

  logic [size-1:0] mem [depth];
  logic [size-1:0] ram_q;
  logic            ram_vld;

  logic [size-1:0] e0;
  logic [size-1:0] e1;
  logic [1:0]      sk_cnt;

  logic       accept;
  logic       go_rd;
  logic       pop;
  logic       ren;
  logic [2:0] occ;

  assign s_tready = (st == FILL);
  assign accept   = s_tready && s_tvalid && !start;
  assign go_rd    = (st == FROZEN) && rd_start && !start
                    && (sample_count != '0);
  assign rd_valid = (sk_cnt != 2'd0);
  assign rd_data  = e0;
  assign pop      = rd_valid && rd_ready;
  assign state    = st;

  // Occupancy the skid will see once this cycle's pop retires;
  // a new read is issued only if its data is sure to find room.
  assign occ = 3'(sk_cnt) + 3'(ram_vld) - 3'(pop);

  // Read address and read-issue decision
  always_comb begin
    raddr = rp;
    ren   = 1'b0;
    if (go_rd) begin
      raddr = wrapped ? wp : '0;
      ren   = 1'b1;
    end else if (st == READOUT && !start
                 && to_issue != '0 && occ < 3'd2) begin
      ren = 1'b1;
    end
  end

  // Sample RAM: one write port, synchronous read port
  always_ff @(posedge clk) begin
    if (accept)
      mem[wp] <= s_tdata;
    if (ren)
      ram_q <= mem[raddr];
  end

  // Control FSM, pointers and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      wp           <= '0;
      rp           <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      remaining    <= '0;
      to_issue     <= '0;
      ram_vld      <= 1'b0;
    end else if (start) begin
      st           <= FILL;
      wp           <= '0;
      rp           <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      remaining    <= '0;
      to_issue     <= '0;
      ram_vld      <= 1'b0;
    end else begin
      ram_vld <= ren;
      if (accept) begin
        wp <= wp + 1'b1;
        if (wp == '1)
          wrapped <= 1'b1;
        if (sample_count != full)
          sample_count <= sample_count + 1'b1;
      end
      if (ren)
        rp <= raddr + 1'b1;
      if (go_rd) begin
        remaining <= sample_count;
        to_issue  <= sample_count - 1'b1;
      end else begin
        if (ren)
          to_issue <= to_issue - 1'b1;
        if (pop)
          remaining <= remaining - 1'b1;
      end
      unique case (st)
        IDLE: ;
        FILL:
          if (capture_done)
            st <= FROZEN;
        FROZEN:
          if (go_rd)
            st <= READOUT;
        READOUT:
          if (pop && remaining == 1)
            st <= FROZEN;
        default: st <= IDLE;
      endcase
    end
  end

  // Two-entry output skid fed by the RAM read stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0     <= '0;
      e1     <= '0;
      sk_cnt <= 2'd0;
    end else if (start) begin
      sk_cnt <= 2'd0;
    end else begin
      unique case (sk_cnt)
        2'd0: begin
          if (ram_vld) begin
            e0     <= ram_q;
            sk_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (ram_vld && pop) begin
            e0 <= ram_q;
          end else if (ram_vld) begin
            e1     <= ram_q;
            sk_cnt <= 2'd2;
          end else if (pop) begin
            sk_cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            e0 <= e1;
            if (ram_vld)
              e1 <= ram_q;
            else
              sk_cnt <= 2'd1;
          end
        end
        default: sk_cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sink.sv
// tb_capture_sink: scoreboard bench for capture_sink
// with a 16-deep buffer.
module tb_capture_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        start = 1'b0;
  logic        capture_done = 1'b0;
  logic        rd_start = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [4:0]  sample_count;
  logic        wrapped;
  logic [1:0]  state;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];

  capture_sink #(.size(32), .addr_w(4)) dut (
    .clk(clk),
    .reset(reset),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .start(start),
    .capture_done(capture_done),
    .rd_start(rd_start),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .sample_count(sample_count),
    .wrapped(wrapped),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic do_start();
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // one accepted beat; model keeps the newest 16 samples
  task automatic stream(input logic [31:0] v);
    s_tvalid = 1'b1;
    s_tdata  = v;
    exp_q.push_back(v);
    if (exp_q.size() > 16)
      void'(exp_q.pop_front());
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic freeze();
    capture_done = 1'b1;
    @(posedge clk); #1;
    capture_done = 1'b0;
  endtask

  task automatic read_out(input int n, input bit bp);
    int cyc;
    int got;
    bit stall;
    logic [31:0] held;
    logic [31:0] e;
    cyc = 0;
    got = 0;
    stall = 0;
    held = '0;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rd_valid !== 1'b0)
      $display("FAIL rd_lat0 got %b want 0", rd_valid);
    else n_pass++;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rd_valid !== 1'b0)
      $display("FAIL rd_lat1 got %b want 0", rd_valid);
    else n_pass++;
    @(posedge clk); #1;
    while (got < n && cyc < 300) begin
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cyc == 0) begin
        n_chk++;
        if (rd_valid !== 1'b1)
          $display("FAIL rd_first got %b want 1", rd_valid);
        else n_pass++;
      end
      if (stall) begin
        n_chk++;
        if (rd_valid !== 1'b1 || rd_data !== held)
          $display("FAIL rd_stable got %b/%0h want 1/%0h",
                   rd_valid, rd_data, held);
        else n_pass++;
      end
      stall = 0;
      if (rd_valid === 1'b1) begin
        if (rd_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          n_chk++;
          if (rd_data !== e)
            $display("FAIL rd_data got %0h want %0h", rd_data, e);
          else n_pass++;
          got++;
        end else begin
          stall = 1;
          held = rd_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++;
    if (got != n)
      $display("FAIL rd_count got %0d want %0d", got, n);
    else n_pass++;
    if (!bp) begin
      n_chk++;
      if (cyc != n)
        $display("FAIL rd_nobubble got %0d want %0d", cyc, n);
      else n_pass++;
    end
    rd_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state !== 2'd2 || rd_valid !== 1'b0)
      $display("FAIL rd_end got %0d/%b want 2/0", state, rd_valid);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL rd_left got %0d want 0", exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({s_tready, rd_valid, rd_data, sample_count, wrapped, state}
        !== '0)
      $display("FAIL reset got %b%b %0h %0d %b %0d want all 0",
               s_tready, rd_valid, rd_data, sample_count,
               wrapped, state);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state !== 2'd0 || s_tready !== 1'b0)
      $display("FAIL idle got %0d/%b want 0/0", state, s_tready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_start();
    n_chk++;
    if (s_tready !== 1'b1 || state !== 2'd1)
      $display("FAIL fill got %b/%0d want 1/1", s_tready, state);
    else n_pass++;
    for (int i = 0; i < 5; i++)
      stream(32'hA0 + i);
    freeze();
    @(negedge clk);
    n_chk++;
    if (state !== 2'd2 || sample_count !== 5'd5 || wrapped !== 1'b0)
      $display("FAIL basic_frz got %0d/%0d/%b want 2/5/0",
               state, sample_count, wrapped);
    else n_pass++;
    @(posedge clk); #1;
    read_out(5, 0);
  endtask

  task automatic test_wrap();
    do_start();
    for (int i = 0; i < 20; i++)
      stream(i);
    freeze();
    @(negedge clk);
    n_chk++;
    if (sample_count !== 5'd16 || wrapped !== 1'b1)
      $display("FAIL wrap_cnt got %0d/%b want 16/1",
               sample_count, wrapped);
    else n_pass++;
    @(posedge clk); #1;
    read_out(16, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] v [8];
    do_start();
    for (int i = 0; i < 8; i++) begin
      v[i] = $urandom;
      stream(v[i]);
    end
    freeze();
    read_out(8, 1);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(v[i]);
    read_out(8, 1);
  endtask

  task automatic test_boundary();
    do_start();
    for (int i = 1; i < 4; i++)
      stream(i);
    capture_done = 1'b1;
    stream(32'h55);
    capture_done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = 32'h77;
    @(negedge clk);
    n_chk++;
    if (s_tready !== 1'b0 || state !== 2'd2)
      $display("FAIL bnd_tready got %b/%0d want 0/2",
               s_tready, state);
    else n_pass++;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (sample_count !== 5'd4)
      $display("FAIL bnd_cnt got %0d want 4", sample_count);
    else n_pass++;
    @(posedge clk); #1;
    read_out(4, 0);
  endtask

  task automatic test_restart();
    logic [31:0] e;
    do_start();
    freeze();
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (state !== 2'd2 || rd_valid !== 1'b0)
        $display("FAIL ign_rd got %0d/%b want 2/0", state, rd_valid);
      else n_pass++;
    end
    @(posedge clk); #1;
    do_start();
    for (int i = 0; i < 20; i++)
      stream(32'h100 + i);
    freeze();
    rd_ready = 1'b1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== e)
        $display("FAIL rst_beat got %b/%0h want 1/%0h",
                 rd_valid, rd_data, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state !== 2'd1 || rd_valid !== 1'b0
        || sample_count !== 5'd0 || wrapped !== 1'b0)
      $display("FAIL restart got %0d/%b/%0d/%b want 1/0/0/0",
               state, rd_valid, sample_count, wrapped);
    else n_pass++;
    @(posedge clk); #1;
    exp_q.delete();
    stream(32'hC0);
    stream(32'hC1);
    freeze();
    read_out(2, 0);
  endtask

  task automatic test_async_reset();
    do_start();
    stream(32'hD0);
    stream(32'hD1);
    s_tvalid = 1'b1;
    s_tdata = 32'hD2;
    @(negedge clk);
    n_chk++;
    if (state !== 2'd1 || sample_count !== 5'd2)
      $display("FAIL pre_rst got %0d/%0d want 1/2",
               state, sample_count);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (s_tready !== 1'b0 || state !== 2'd0
        || sample_count !== 5'd0)
      $display("FAIL async_rst got %b/%0d/%0d want 0/0/0",
               s_tready, state, sample_count);
    else n_pass++;
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_boundary();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/capture_sink.md
Name: capture_sink

Overview:
- AXI-stream slave (receiving end) for the sample stream produced by the capture block.
- Stores incoming samples in an on-chip circular buffer. Capture stops when capture's done flag is asserted.
- Host then drains the stored samples oldest-first through a valid/ready read port.
- Sits between the capture block and the host register/DMA interface, in the capture block's main clock domain.

Parameters:
size, 32, sample width in bits; matches capture tdata width.
addr_w, 10, buffer address width; depth = 2**addr_w samples.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
s_tdata  input  size  stream sample data.
s_tvalid  input  1  stream sample valid.
s_tready  output  1  sink ready; high only in FILL.
start  input  1  single-cycle pulse: clear pointers and begin FILL.
capture_done  input  1  level from capture: stop filling.
rd_start  input  1  single-cycle pulse: begin readout (honoured in FROZEN only).
rd_data  output  size  readout sample.
rd_valid  output  1  rd_data valid.
rd_ready  input  1  host accepts rd_data.
sample_count  output  addr_w+1  samples held, saturates at depth.
wrapped  output  1  buffer has overwritten old samples.
state  output  2  IDLE=0, FILL=1, FROZEN=2, READOUT=3.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - s_tready=0, rd_valid=0, rd_data=0, sample_count=0, wrapped=0.
  - Write pointer wp=0, read pointer rp=0, remaining count=0. Output skid entries are emptied.
- Buffer: single RAM with synchronous read (1-cycle latency). One write port and one read port, same clock.
- IDLE:
  - s_tready=0.
  - start -> FILL with wp=0, sample_count=0, wrapped=0.
- FILL:
  - s_tready=1 combinationally from state.
  - Accept on s_tvalid&&s_tready: write mem[wp], wp<=wp+1 mod depth, sample_count<=min(sample_count+1, depth).
  - When wp wraps from depth-1 to 0 on an accepted write, wrapped<=1 (sticky until start).
  - capture_done high -> FROZEN next cycle. A beat accepted in that same cycle is still written.
- FROZEN:
  - s_tready=0; buffer contents and counters held.
  - rd_start with sample_count>0 -> READOUT:
    - rp = wrapped ? wp : 0.
    - remaining = sample_count.
  - rd_start with sample_count=0 is ignored.
- READOUT:
  - Samples are presented oldest-first. rp increments mod depth per RAM read issued.
  - First rd_valid is asserted 2 cycles after the rd_start cycle.
  - With rd_ready held high: one sample per cycle, no bubbles. Implemented with a 2-entry output skid buffer fed by the 1-cycle RAM.
  - rd_data/rd_valid are stable while rd_valid&&!rd_ready. No sample is dropped or duplicated.
  - After remaining beats are accepted, rd_valid=0 and state goes to FROZEN. Contents are preserved, so rd_start may re-read.
  - sample_count is unchanged by readout.
- start in any state (FILL, FROZEN, READOUT):
  - Immediate restart into FILL: pointers and counts are cleared, the skid buffer is flushed, and rd_valid=0 next cycle.
  - start has priority over capture_done and rd_start in the same cycle.
- Simultaneous events:
  - start and capture_done together: FILL wins.
  - capture_done high while in IDLE or FROZEN: no effect.
  - rd_start outside FROZEN: ignored.
- Arithmetic: all pointer arithmetic is modulo depth. sample_count is addr_w+1 bits so the value depth is representable.

Test Plan:
- Basic fill and read:
  - Reset, start, stream 5 beats 0xA0..0xA4, assert capture_done.
  - Expect state=FROZEN, sample_count=5, wrapped=0.
  - rd_start with rd_ready=1 -> rd_valid 2 cycles later, data 0xA0..0xA4 on consecutive cycles, then FROZEN.
- Wrap (addr_w=4, depth 16):
  - Stream 20 beats with values 0..19, then capture_done.
  - Expect sample_count=16, wrapped=1.
  - Readout yields 4..19 in order.
- Backpressure:
  - Readout of 8 samples with rd_ready toggled 1,0,0,1 pseudo-randomly.
  - rd_data must stay stable while stalled; exactly 8 beats in order, none repeated.
- Boundary:
  - Stream beat 0x55 in the same cycle capture_done rises.
  - 0x55 is stored (count includes it); s_tready=0 the following cycle.
  - A beat presented afterwards is not accepted.
- Restart and ignore:
  - rd_start with count=0 in FROZEN -> stays FROZEN, rd_valid=0.
  - start mid-READOUT after 3 beats -> next cycle state=FILL, rd_valid=0, sample_count=0, wrapped=0.
- Async reset:
  - Assert reset mid-FILL between clock edges.
  - Outputs go to reset values immediately (s_tready=0, state=IDLE) without a clock edge.
